// File: rtl/nibble_serial_sub16.sv
// Serial subtractor: d = a - b - b_in, one SLICE-bit slice per clock, LSB first,
// with the borrow rippled through a flop. Optional z/v flags under NIBBLE_SUB_FLAGS_EN.
module nibble_serial_sub16 #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef NIBBLE_SUB_FLAGS_EN
  ,
  output logic             z,
  output logic             v
`endif
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_d;
  logic               r_borrow;
  logic               r_bout;
  logic [CNT_W-1:0]   r_cnt;

  logic [SLICE-1:0]   w_aSlice;
  logic [SLICE-1:0]   w_bSlice;
  logic [SLICE:0]     w_sliceDiff;
  logic [SLICE-1:0]   w_ds;
  logic               w_bo;
  logic [WIDTH-1:0]   w_dNext;
  logic               w_accept;
  logic               w_lastSlice;

  // Mux the captured operands down to the slice selected by the counter.
  always_comb begin
    w_aSlice = '0;
    w_bSlice = '0;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_aSlice = r_a[i*SLICE +: SLICE];
        w_bSlice = r_b[i*SLICE +: SLICE];
      end
    end
  end

  assign w_sliceDiff = {1'b0, w_aSlice} - {1'b0, w_bSlice} - {{SLICE{1'b0}}, r_borrow};
  assign w_ds        = w_sliceDiff[SLICE-1:0];
  assign w_bo        = w_sliceDiff[SLICE];
  assign w_lastSlice = (r_cnt == CNT_W'(N - 1));

  // Result with the current slice merged in; untouched slices keep the old result.
  always_comb begin
    w_dNext = r_d;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_dNext[i*SLICE +: SLICE] = w_ds;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_lastSlice) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= b_in;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_d      <= w_dNext;
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      if (w_lastSlice) begin
        r_bout <= w_bo;
      end
    end
  end

`ifdef NIBBLE_SUB_FLAGS_EN
  logic r_z;
  logic r_v;

  // Flags are judged on the complete result, so they use the merged final value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= 1'b0;
      r_v <= 1'b0;
    end else if ((r_state == RUN) && w_lastSlice) begin
      r_z <= (w_dNext == '0);
      r_v <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dNext[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  assign z = r_z;
  assign v = r_v;
`endif

  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign d     = r_d;
  assign b_out = r_bout;

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Self-checking bench for nibble_serial_sub16: directed vector table, random
// operands against an arithmetic reference, and multi-cycle handshake corner cases.
module tb_nibble_serial_sub16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        b_out;
`ifdef NIBBLE_SUB_FLAGS_EN
  logic        z;
  logic        v;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_sub16 #(
    .WIDTH(16),
    .SLICE(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
`ifdef NIBBLE_SUB_FLAGS_EN
    ,
    .z     (z),
    .v     (v)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] expD;
    logic        expBout;
    logic        expZ;
    logic        expV;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, independent of slicing.
  function automatic logic [18:0] refModel(input logic [15:0] ra, input logic [15:0] rb, input logic rbin);
    int          diff;
    logic [15:0] rd;
    logic        rbo;
    logic        rz;
    logic        rv;
    diff = int'(ra) - int'(rb) - int'(rbin);
    rd   = diff[15:0];
    rbo  = (diff < 0);
    rz   = (rd == 16'h0000);
    rv   = (ra[15] != rb[15]) && (rd[15] != ra[15]);
    return {rv, rz, rbo, rd};
  endfunction

  // Leaves the caller at the falling edge of the done cycle.
  task automatic applyStimulus(input logic [15:0] sa, input logic [15:0] sb, input logic sbin);
    @(negedge clk);
    a     = sa;
    b     = sb;
    b_in  = sbin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~sa;
    b     = ~sb;
    for (int m = 0; m < 4; m++) begin
      checkOutput("busyDuringRun", busy, 1);
      checkOutput("doneDuringRun", done, 0);
      @(negedge clk);
    end
    checkOutput("donePulse", done, 1);
    checkOutput("busyInDone", busy, 0);
  endtask

  initial begin
    logic [18:0] expRes;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h1E1F, 1'b1, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    b_in  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstD", d, 0);
    checkOutput("rstBout", b_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin);
      checkOutput($sformatf("vec%0d_d", i), d, vecs[i].expD);
      checkOutput($sformatf("vec%0d_bout", i), b_out, vecs[i].expBout);
`ifdef NIBBLE_SUB_FLAGS_EN
      checkOutput($sformatf("vec%0d_z", i), z, vecs[i].expZ);
      checkOutput($sformatf("vec%0d_v", i), v, vecs[i].expV);
`endif
    end

    for (int i = 0; i < 25; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (i < 5) rb = ra;
      expRes = refModel(ra, rb, rbin);
      applyStimulus(ra, rb, rbin);
      checkOutput("randD", d, expRes[15:0]);
      checkOutput("randBout", b_out, expRes[16]);
`ifdef NIBBLE_SUB_FLAGS_EN
      checkOutput("randZ", z, expRes[17]);
      checkOutput("randV", v, expRes[18]);
`endif
    end

    // start pulsed mid-run with new operands must be ignored.
    @(negedge clk);
    a     = 16'h00FF;
    b     = 16'h0001;
    b_in  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("ignBusy0", busy, 1);
    a     = 16'h1234;
    b     = 16'h0FFF;
    b_in  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int m = 1; m < 4; m++) begin
      checkOutput("ignBusy", busy, 1);
      checkOutput("ignDoneEarly", done, 0);
      @(negedge clk);
    end
    checkOutput("ignDone", done, 1);
    checkOutput("ignD", d, 16'h00FE);
    checkOutput("ignBout", b_out, 0);
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      checkOutput("ignNoExtraDone", done, 0);
      checkOutput("ignIdleBusy", busy, 0);
    end

    // start held high: a result every five cycles, no bubble.
    @(negedge clk);
    a     = 16'd5;
    b     = 16'd3;
    b_in  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 15; m++) begin
      checkOutput($sformatf("b2bDone%0d", m), done, ((m % 5) == 4) ? 1 : 0);
      checkOutput($sformatf("b2bBusy%0d", m), busy, ((m % 5) == 4) ? 0 : 1);
      if ((m % 5) == 4) checkOutput("b2bD", d, 16'h0002);
      if (m == 14) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2bEndBusy", busy, 0);
    checkOutput("b2bEndDone", done, 0);

    // Reset two cycles into RUN clears everything at once.
    @(negedge clk);
    a     = 16'hFFFF;
    b     = 16'h0001;
    b_in  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstD", d, 0);
    checkOutput("midRstBout", b_out, 0);
`ifdef NIBBLE_SUB_FLAGS_EN
    checkOutput("midRstZ", z, 0);
    checkOutput("midRstV", v, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 6; m++) begin
      @(negedge clk);
      checkOutput("postRstDone", done, 0);
      checkOutput("postRstBusy", busy, 0);
    end

    applyStimulus(16'hABCD, 16'h1111, 1'b1);
    checkOutput("recoverD", d, 16'h9ABB);
    checkOutput("recoverBout", b_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
